multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ILLEGAL_HALT, default 0: 1 = an unknown opcode enters HALT; 0 = an unknown opcode returns to FETCH as a NOP.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port srst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports op, input, 7 and funct3, input, 3: opcode and funct3 fields from the instruction register.
REQ-005 SHALL have port funct7b5, input, 1: instruction bit 30.
REQ-006 SHALL have port zero, input, 1: ALU zero flag.
REQ-007 SHALL have outputs pc_write, ir_write, reg_w, mem_w and adr_src, each 1 bit: write enables and memory-address select (0 = PC, 1 = ALU result register).
REQ-008 SHALL have outputs alu_src_a, 2 (00 PC, 01 oldPC, 10 rs1) and alu_src_b, 2 (00 rs2, 01 imm_ext, 10 constant 4).
REQ-009 SHALL have outputs result_src, 2 (00 ALU register, 01 read data, 10 ALU result), imm_src, 2 and alu_control, 3.
REQ-010 SHALL have outputs halted, 1 and retired, 32: count of completed instructions.

Function
REQ-011 SHALL implement the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL and HALT, with exactly one state per cycle.
REQ-012 Transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR (lw 0000011, sw 0100011), EXECR (0110011), EXECI (0010011), BEQ (1100011), JAL (1101111); any other opcode -> HALT if ILLEGAL_HALT, else FETCH.
- MEMADR->MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD->MEMWB; EXECR/EXECI->ALUWB; JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BEQ, and a non-halting illegal opcode in DECODE -> FETCH.
- HALT->HALT.
REQ-013 Moore outputs per state (unlisted signals are 0):
- FETCH: ir_write=1, pc_update=1, a=00, b=10, result_src=10.
- DECODE: a=01, b=01.
- MEMADR: a=10, b=01.
- MEMREAD: adr_src=1.
- MEMWB: result_src=01, reg_w=1.
- MEMWRITE: adr_src=1, mem_w=1.
- EXECR: a=10, b=00, aluop=10.
- EXECI: a=10, b=01, aluop=10.
- BEQ: a=10, b=00, aluop=01, branch=1.
- JAL: a=01, b=10, pc_update=1.
- ALUWB: reg_w=1.
- HALT: all enables 0.
REQ-014 pc_write SHALL equal pc_update OR (branch AND zero), combinationally in the same cycle as zero.
REQ-015 imm_src SHALL decode from op combinationally: I-type/lw 00, sw 01, beq 10, jal 11, others 00.
REQ-016 alu_control SHALL be:
- aluop 00 -> 000 (add); aluop 01 -> 001 (sub).
- aluop 10 by funct3: 000 -> 001 if op[5] AND funct7b5, else 000; 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); others -> 000.
REQ-017 retired SHALL increment by 1, wrapping modulo 2^32, on each clock edge that leaves MEMWB, MEMWRITE, ALUWB or BEQ; illegal NOPs SHALL not count.
REQ-018 halted SHALL be 1 exactly when the state is HALT.
REQ-019 Instruction latency SHALL be: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.

Reset
REQ-020 srst high at a clock edge SHALL set state=FETCH and retired=0, overriding every transition, including from HALT and mid-instruction.
REQ-021 While srst is high, pc_write, ir_write, reg_w and mem_w SHALL be forced to 0; other outputs SHALL take their FETCH values and halted SHALL be 0.

Structure
REQ-022 The state enum, opcode constants, aluop encoding and alu_control encodings SHALL reside in the shared package riscv_pkg.
REQ-023 ALU control decoding SHALL be a combinational sub-module alu_decoder (aluop, funct3, op5, funct7b5 -> alu_control); the FSM and retired counter SHALL stay in multicycle_ctrl.

Verification
REQ-024 Release srst and drive op=0000011 (lw) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; reg_w=1 only in MEMWB; retired=1.
REQ-025 Drive op=0110011, funct3=000, funct7b5=1 -> alu_control=001 in EXECR; reg_w in ALUWB; 4 cycles total.
REQ-026 Drive BEQ with zero=1, then again with zero=0 -> pc_write=1 in BEQ for the first only; both increment retired.
REQ-027 Drive op=1111111 with ILLEGAL_HALT=1 -> HALT with halted=1 and all enables 0 for 10 cycles; srst -> FETCH. With ILLEGAL_HALT=0 -> FETCH after DECODE and retired unchanged.
REQ-028 Assert srst during MEMWRITE -> mem_w=0 in that cycle, next state FETCH, retired=0.
REQ-029 Preload retired to 0xFFFFFFFF by force, complete sw -> retired=0x00000000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V controller: state encoding,
// opcodes, ALU operation classes and the per-state Moore control word.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, HALT
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       ir_write;
    logic       pc_update;
    logic       adr_src;
    logic       mem_w;
    logic       reg_w;
    logic       branch;
    logic       halted;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore control word asserted while the FSM sits in state s.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_a  = 2'b00;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.result_src = 2'b01; c.reg_w = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_w = 1'b1; end
      EXECR:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.aluop = ALUOP_FUNCT; end
      EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.aluop = ALUOP_FUNCT; end
      BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.aluop     = ALUOP_SUB;
        c.branch    = 1'b1;
      end
      JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      ALUWB:    c.reg_w = 1'b1;
      HALT:     c.halted = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the operation class and the
// instruction's funct fields.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type with bit 30 set subtracts; addi ignores funct7.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main controller: state machine with registered Moore
// control word, branch-qualified PC write and a retired-instruction counter.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_w,
  output logic        mem_w,
  output logic        adr_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  imm_src,
  output logic [2:0]  alu_control,
  output logic        halted,
  output logic [31:0] retired
);

  state_t      state_reg;
  state_t      state_next;
  ctrl_t       ctrl_reg;
  ctrl_t       ctrl_eff;
  logic [31:0] retired_reg;
  logic        retire;
  logic [3:0]  en_raw;
  logic [3:0]  en;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECR;
          OP_ITYPE:     state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = ILLEGAL_HALT ? HALT : FETCH;
        endcase
      end
      MEMADR:                      state_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:                     state_next = MEMWB;
      EXECR, EXECI, JAL:           state_next = ALUWB;
      MEMWB, MEMWRITE, ALUWB, BEQ: state_next = FETCH;
      HALT:                        state_next = HALT;
      default:                     state_next = FETCH;
    endcase
  end

  // Illegal NOPs leave from DECODE and are deliberately not counted.
  assign retire = (state_reg == MEMWB) || (state_reg == MEMWRITE) ||
                  (state_reg == ALUWB) || (state_reg == BEQ);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg   <= FETCH;
      ctrl_reg    <= state_ctrl(FETCH);
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= state_ctrl(state_next);
      if (retire) begin
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  // During reset the datapath sees FETCH steering with all writes suppressed.
  assign ctrl_eff = srst ? state_ctrl(FETCH) : ctrl_reg;

  assign en_raw = {ctrl_eff.pc_update | (ctrl_eff.branch & zero),
                   ctrl_eff.ir_write, ctrl_eff.reg_w, ctrl_eff.mem_w};

  for (genvar gi = 0; gi < 4; gi++) begin : g_en_gate
    assign en[gi] = en_raw[gi] & ~srst;
  end

  assign {pc_write, ir_write, reg_w, mem_w} = en;
  assign adr_src    = ctrl_eff.adr_src;
  assign alu_src_a  = ctrl_eff.alu_src_a;
  assign alu_src_b  = ctrl_eff.alu_src_b;
  assign result_src = ctrl_eff.result_src;
  assign halted     = ctrl_eff.halted;
  assign imm_src    = imm_sel(op);
  assign retired    = retired_reg;

  alu_decoder u_alu_decoder (
    .aluop       (ctrl_eff.aluop),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule
